// File: rtl/sample_byte_packer.sv
// Serialises PCM samples LSB-first into an 8-bit FIFO, prefixing each frame of
// FRAME_SAMPLES samples with a sync/sequence header and counting dropped samples.
module sample_byte_packer #(
  parameter int         DATA_SIZE     = 24,
  parameter int         FRAME_SAMPLES = 256,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid_i,
  input  logic [DATA_SIZE-1:0] sample_data_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_wr_en_o,
  output logic [7:0]           fifo_write_data_o,
  output logic                 busy_o,
  output logic [15:0]          drop_count_o,
  output logic                 overflow_o
);

  localparam int NB    = (DATA_SIZE + 7) / 8;
  localparam int PAD_W = NB * 8;

  typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_SEQ, DATA, GAP} state_t;

  state_t               state, state_nx;
  state_t               resume, resume_nx;
  logic [1:0]           idx, idx_nx;
  logic [DATA_SIZE-1:0] latch, latch_nx;
  logic [15:0]          sample_cnt, sample_cnt_nx;
  logic [7:0]           seq, seq_nx;
  logic                 wr_en, wr_en_nx;
  logic [7:0]           wr_data, wr_data_nx;
  logic [15:0]          drops, drops_nx;
  logic                 ovf, ovf_nx;
  logic [PAD_W-1:0]     padded;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [PAD_W-1:0] v, input logic [1:0] i);
    logic [PAD_W-1:0] sh;
    sh = v >> {i, 3'b000};
    return sh[7:0];
  endfunction

  // Zero-extend so pad bits in the top byte are never sign bits.
  assign padded = PAD_W'(latch);

  always_comb begin
    state_nx      = state;
    resume_nx     = resume;
    idx_nx        = idx;
    latch_nx      = latch;
    sample_cnt_nx = sample_cnt;
    seq_nx        = seq;
    wr_en_nx      = 1'b0;
    wr_data_nx    = wr_data;
    drops_nx      = drops;
    ovf_nx        = ovf;

    if (sample_valid_i && state != IDLE) begin
      drops_nx = sat_inc(drops);
      ovf_nx   = 1'b1;
    end

    case (state)
      IDLE: begin
        if (sample_valid_i) begin
          latch_nx = sample_data_i;
          idx_nx   = 2'd0;
          state_nx = (sample_cnt == 16'd0) ? HDR_SYNC : DATA;
        end
      end
      HDR_SYNC: begin
        if (!fifo_full_i) begin
          wr_en_nx   = 1'b1;
          wr_data_nx = SYNC_BYTE;
          resume_nx  = HDR_SEQ;
          state_nx   = GAP;
        end
      end
      HDR_SEQ: begin
        if (!fifo_full_i) begin
          wr_en_nx   = 1'b1;
          wr_data_nx = seq;
          resume_nx  = DATA;
          state_nx   = GAP;
        end
      end
      DATA: begin
        if (!fifo_full_i) begin
          wr_en_nx   = 1'b1;
          wr_data_nx = byte_of(padded, idx);
          state_nx   = GAP;
          if (idx == 2'(NB - 1)) begin
            resume_nx = IDLE;
            if (sample_cnt == 16'(FRAME_SAMPLES - 1)) begin
              sample_cnt_nx = 16'd0;
              seq_nx        = seq + 8'd1;
            end else begin
              sample_cnt_nx = sample_cnt + 16'd1;
            end
          end else begin
            resume_nx = DATA;
            idx_nx    = idx + 2'd1;
          end
        end
      end
      // One dead cycle lets a full flag caused by the last write reach us.
      GAP:     state_nx = resume;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resume     <= IDLE;
      idx        <= 2'd0;
      latch      <= '0;
      sample_cnt <= 16'd0;
      seq        <= 8'd0;
      wr_en      <= 1'b0;
      wr_data    <= 8'd0;
      drops      <= 16'd0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nx;
      resume     <= resume_nx;
      idx        <= idx_nx;
      latch      <= latch_nx;
      sample_cnt <= sample_cnt_nx;
      seq        <= seq_nx;
      wr_en      <= wr_en_nx;
      wr_data    <= wr_data_nx;
      drops      <= drops_nx;
      ovf        <= ovf_nx;
    end
  end

  assign fifo_wr_en_o      = wr_en;
  assign fifo_write_data_o = wr_data;
  assign busy_o            = (state != IDLE);
  assign drop_count_o      = drops;
  assign overflow_o        = ovf;

endmodule

// File: tb/tb_sample_byte_packer.sv
// Bench for sample_byte_packer: two instances (24-bit/2-sample frames and
// 12-bit/3-sample frames) checked each cycle against a byte-stream reference model.
module tb_sample_byte_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid;
  logic        full;
  logic [23:0] data;
  logic        wr_en [2];
  logic [7:0]  wdata [2];
  logic        busy  [2];
  logic [15:0] dcnt  [2];
  logic        ovf   [2];

  sample_byte_packer #(.DATA_SIZE(24), .FRAME_SAMPLES(2), .SYNC_BYTE(8'hA5)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_valid_i(valid), .sample_data_i(data),
    .fifo_full_i(full), .fifo_wr_en_o(wr_en[0]), .fifo_write_data_o(wdata[0]),
    .busy_o(busy[0]), .drop_count_o(dcnt[0]), .overflow_o(ovf[0]));

  sample_byte_packer #(.DATA_SIZE(12), .FRAME_SAMPLES(3), .SYNC_BYTE(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_valid_i(valid), .sample_data_i(data[11:0]),
    .fifo_full_i(full), .fifo_wr_en_o(wr_en[1]), .fifo_write_data_o(wdata[1]),
    .busy_o(busy[1]), .drop_count_o(dcnt[1]), .overflow_o(ovf[1]));

  localparam int DSZ [2] = '{24, 12};
  localparam int NBM [2] = '{3, 2};
  localparam int FRM [2] = '{2, 3};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit armed = 0;
  bit post_rst = 0;
  bit full_prev = 0;

  // reference model: expected byte stream and accept/drop bookkeeping
  logic [7:0] qb [2][16];
  int  qh [2], qt [2], earliest [2], cnt [2], seq [2], drops [2];
  bit  busy_m [2], ovf_m [2];

  // write log for hand-computed checks
  logic [7:0] wlog_d [2][64];
  int  wlog_c [2][64];
  int  wn [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    qb[k][qt[k] % 16] = b;
    qt[k]++;
  endtask

  task automatic model_reset(input int k);
    qh[k] = 0; qt[k] = 0; earliest[k] = 0; cnt[k] = 0; seq[k] = 0;
    drops[k] = 0; busy_m[k] = 0; ovf_m[k] = 0;
  endtask

  task automatic accept(input int k, input logic [23:0] d);
    logic [31:0] v;
    if (cnt[k] == 0) begin
      push(k, 8'hA5);
      push(k, 8'(seq[k]));
    end
    v = 32'(d) & ((32'h1 << DSZ[k]) - 32'h1);
    for (int b = 0; b < NBM[k]; b++) push(k, 8'((v >> (8 * b)) & 32'hFF));
    busy_m[k]   = 1;
    earliest[k] = cyc + 2;
  endtask

  // One clock cycle: compare at negedge, advance model, drive next inputs after posedge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic ew;
      bit   was_busy;
      ew = (qt[k] != qh[k]) && (cyc >= earliest[k]) && !full_prev;
      if (armed) begin
        chk("wr_en", k, 32'(wr_en[k]), 32'(ew));
        if (ew) chk("byte", k, 32'(wdata[k]), 32'(qb[k][qh[k] % 16]));
        chk("busy", k, 32'(busy[k]), 32'(busy_m[k]));
        chk("drop_count", k, 32'(dcnt[k]), 32'(drops[k]));
        chk("overflow", k, 32'(ovf[k]), 32'(ovf_m[k]));
        if (post_rst) chk("data_after_reset", k, 32'(wdata[k]), 32'h0);
        if (wr_en[k] === 1'b1 && wn[k] < 64) begin
          wlog_d[k][wn[k]] = wdata[k];
          wlog_c[k][wn[k]] = cyc;
          wn[k]++;
        end
      end
      if (!rst_n) model_reset(k);
      else begin
        was_busy = busy_m[k];
        if (valid) begin
          if (was_busy) begin
            if (drops[k] < 65535) drops[k]++;
            ovf_m[k] = 1;
          end else accept(k, data);
        end
        if (ew) begin
          qh[k]++;
          earliest[k] = cyc + 2;
          if (qh[k] == qt[k]) begin
            busy_m[k] = 0;
            cnt[k] = (cnt[k] + 1) % FRM[k];
            if (cnt[k] == 0) seq[k] = (seq[k] + 1) % 256;
          end
        end
      end
    end
    post_rst  = !rst_n;
    if (!rst_n) armed = 1;
    full_prev = full;
    cyc++;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic clear_log();
    wn[0] = 0;
    wn[1] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [23:0] d);
    data  = d;
    valid = 1'b1;
    step();
  endtask

  task automatic wait_writes(input int k, input int n);
    for (int i = 0; i < 60 && wn[k] < n; i++) step();
    chk("wait_writes", k, 32'(wn[k] >= n), 32'h1);
  endtask

  // Bytes listed first-written first, right-aligned in exp.
  task automatic expect_bytes(input string nm, input int k, input int n, input logic [127:0] exp);
    chk({nm, "_count"}, k, 32'(wn[k]), 32'(n));
    for (int i = 0; i < n; i++)
      chk(nm, k, 32'(wlog_d[k][i]), 32'(exp[8 * (n - 1 - i) +: 8]));
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; valid = 1'b0; full = 1'b0; data = '0;
    for (int k = 0; k < 2; k++) model_reset(k);
    step();
    do_reset();

    // single sample with header, no backpressure
    clear_log();
    c0 = cyc;
    send(24'h123456);
    repeat (14) step();
    expect_bytes("t1_bytes", 0, 5, {8'hA5, 8'h00, 8'h56, 8'h34, 8'h12});
    expect_bytes("t1_bytes", 1, 4, {8'hA5, 8'h00, 8'h56, 8'h04});
    chk("t1_latency", 0, 32'(wlog_c[0][0] - c0), 32'd2);
    chk("t1_spacing", 0, 32'(wlog_c[0][1] - wlog_c[0][0]), 32'd2);

    // framing: header every FRAME_SAMPLES samples with incrementing sequence
    do_reset();
    clear_log();
    for (int s = 1; s <= 3; s++) begin
      send(24'(s));
      repeat (14) step();
    end
    expect_bytes("t2_frame", 0, 13, {8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
                                     8'h00, 8'hA5, 8'h01, 8'h03, 8'h00, 8'h00});
    expect_bytes("t2_frame", 1, 8, {8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00});

    // backpressure stall right after byte 0x56
    do_reset();
    clear_log();
    send(24'h123456);
    wait_writes(0, 3);
    full = 1'b1;
    repeat (10) step();
    full = 1'b0;
    repeat (20) step();
    expect_bytes("t3_stall", 0, 5, {8'hA5, 8'h00, 8'h56, 8'h34, 8'h12});
    chk("t3_resume_gap", 0, 32'(wlog_c[0][3] - wlog_c[0][2]), 32'd12);

    // sample arriving while busy is dropped
    do_reset();
    clear_log();
    send(24'h0000AA);
    step();
    step();
    send(24'h0000BB);
    repeat (16) step();
    expect_bytes("t4_first_only", 0, 5, {8'hA5, 8'h00, 8'hAA, 8'h00, 8'h00});
    chk("t4_drop", 0, 32'(dcnt[0]), 32'd1);
    repeat (10) step();
    chk("t4_overflow_sticky", 0, 32'(ovf[0]), 32'd1);

    // reset mid-sample, after a drop, restarts the frame
    do_reset();
    clear_log();
    send(24'h112233);
    send(24'h445566);
    wait_writes(0, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t5_busy", 0, 32'(busy[0]), 32'd0);
    chk("t5_drop", 0, 32'(dcnt[0]), 32'd0);
    clear_log();
    send(24'h000777);
    repeat (14) step();
    expect_bytes("t5_restart", 0, 5, {8'hA5, 8'h00, 8'h77, 8'h07, 8'h00});

    // 12-bit sample with zero pad bits, then drop-counter saturation
    do_reset();
    clear_log();
    send(24'hFFFABC);
    repeat (14) step();
    expect_bytes("t6_pad", 1, 4, {8'hA5, 8'h00, 8'hBC, 8'h0A});
    send(24'h000001);
    full = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      data  = 24'($urandom);
      valid = 1'b1;
      step();
    end
    chk("t6_sat", 0, 32'(dcnt[0]), 32'hFFFF);
    chk("t6_sat", 1, 32'(dcnt[1]), 32'hFFFF);
    full = 1'b0;
    repeat (20) step();

    // randomized traffic with backpressure and occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      data  = 24'($urandom);
      valid = ($urandom_range(0, 5) == 0);
      full  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
      rst_n = 1'b1;
    end
    full = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
